// File: rtl/z80_bus_responder_pkg.sv
// Shared types, register offsets and helpers for the Z80 bus responder.
package z80_bus_responder_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IRQ_N  = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [1:0] REG_MASK   = 2'd0;
    localparam logic [1:0] REG_PEND   = 2'd1;
    localparam logic [1:0] REG_VBASE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [DATA_W-1:0] IDLE_DATA = 8'hFF;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_MEM,
        CYC_IO,
        CYC_ACK
    } cyc_e;

    typedef struct packed {
        logic              en;
        logic [1:0]        off;
        logic [DATA_W-1:0] data;
    } io_wr_t;

    // MREQ together with a non-ack IORQ is a malformed strobe pair and is ignored.
    function automatic cyc_e decode_cycle(input logic mreq, input logic iorq, input logic m1);
        cyc_e c;
        c = CYC_IDLE;
        if (mreq && !iorq)
            c = CYC_MEM;
        else if (iorq && m1)
            c = CYC_ACK;
        else if (iorq && !m1 && !mreq)
            c = CYC_IO;
        return c;
    endfunction

    // Bit 0 has the highest priority.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [IRQ_N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = IRQ_N - 1; i >= 0; i--)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// CPU-side Z80 bus: strobes/address/data from the CPU, data/wait/interrupts back.
interface z80_bus_responder_if;
    import z80_bus_responder_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_do;
    logic              cpu_wr;
    logic              cpu_mreq;
    logic              cpu_iorq;
    logic              cpu_m1;
    logic              cpu_halt;
    logic [DATA_W-1:0] cpu_di;
    logic              cpu_wait;
    logic              cpu_int;
    logic              cpu_nmi;

    modport master (
        output cpu_addr, cpu_do, cpu_wr, cpu_mreq, cpu_iorq, cpu_m1, cpu_halt,
        input  cpu_di, cpu_wait, cpu_int, cpu_nmi
    );

    modport slave (
        input  cpu_addr, cpu_do, cpu_wr, cpu_mreq, cpu_iorq, cpu_m1, cpu_halt,
        output cpu_di, cpu_wait, cpu_int, cpu_nmi
    );

endinterface

// File: rtl/z80_irq_ctrl.sv
// Interrupt block: edge capture, MASK/PEND/VBASE registers, priority vector and NMI pulse.
module z80_irq_ctrl
    import z80_bus_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IRQ_N-1:0]  irq_req,
    input  logic              nmi_req,
    input  io_wr_t            io_wr,
    input  logic              ack,
    output logic [DATA_W-1:0] mask,
    output logic [DATA_W-1:0] pend,
    output logic [DATA_W-1:0] vbase,
    output logic              int_c,
    output logic [DATA_W-1:0] vec_c,
    output logic              nmi
);

    logic [IRQ_N-1:0]  irq_q;
    logic              nmi_q;
    logic              ack_q;
    logic [DATA_W-1:0] vec_q;

    logic [IRQ_N-1:0]  elig_c;
    logic [IRQ_N-1:0]  set_c;
    logic [IRQ_N-1:0]  clr_c;
    logic [IRQ_N-1:0]  onehot_c;
    logic [IDX_W-1:0]  idx_c;
    logic              ack_first_c;
    logic [DATA_W-1:0] vec_now_c;

    // Vector is taken on the first ACK clock and held for the rest of a stretched ACK.
    always_comb begin
        elig_c      = pend & mask;
        idx_c       = lowest_set(elig_c);
        ack_first_c = ack & ~ack_q;
        set_c       = irq_req & ~irq_q;
        onehot_c    = '0;
        onehot_c[idx_c] = 1'b1;
        vec_now_c   = (|elig_c) ? {vbase[7:4], idx_c, 1'b0} : IDLE_DATA;
        clr_c       = '0;
        if (io_wr.en && io_wr.off == REG_PEND)
            clr_c = io_wr.data;
        if (ack_first_c && (|elig_c))
            clr_c = clr_c | onehot_c;
        vec_c = ack_first_c ? vec_now_c : vec_q;
        int_c = |elig_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= '0;
            nmi_q <= 1'b0;
            ack_q <= 1'b0;
            nmi   <= 1'b0;
            pend  <= '0;
            mask  <= '0;
            vbase <= '0;
            vec_q <= IDLE_DATA;
        end else begin
            irq_q <= irq_req;
            nmi_q <= nmi_req;
            ack_q <= ack;
            nmi   <= nmi_req & ~nmi_q;
            pend  <= (pend & ~clr_c) | set_c;
            if (ack_first_c)
                vec_q <= vec_now_c;
            if (io_wr.en && io_wr.off == REG_MASK)
                mask <= io_wr.data;
            if (io_wr.en && io_wr.off == REG_VBASE)
                vbase <= {io_wr.data[7:4], 4'h0};
        end
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: wait-stated memory bridge, 4-register interrupt I/O block and IM2 vector.
module z80_bus_responder
    import z80_bus_responder_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [7:0]  IO_BASE  = 8'hF0
) (
    input  logic                clk,
    input  logic                rst,
    z80_bus_responder_if.slave  bus,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [IRQ_N-1:0]    irq_req,
    input  logic                nmi_req
);

    localparam logic [CNT_W-1:0] WAIT_N = CNT_W'(MEM_WAIT);

    cyc_e              cyc_c;
    logic [CNT_W-1:0]  cnt;
    logic              mem_abort;
    logic              mem_active_c;
    logic              mem_ready_c;
    logic              io_hit_c;
    io_wr_t            io_wr_c;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] pend;
    logic [DATA_W-1:0] vbase;
    logic [DATA_W-1:0] vec_c;
    logic [DATA_W-1:0] io_rdata_c;
    logic              int_c;

    assign cyc_c        = decode_cycle(bus.cpu_mreq, bus.cpu_iorq, bus.cpu_m1);
    assign io_hit_c     = (bus.cpu_addr[7:2] == IO_BASE[7:2]);
    assign mem_active_c = !rst && (cyc_c == CYC_MEM) && !mem_abort;
    assign mem_ready_c  = mem_active_c && (cnt >= WAIT_N);

    assign mem_addr     = bus.cpu_addr;
    assign mem_wdata    = bus.cpu_do;
    assign mem_we       = mem_ready_c && bus.cpu_wr;
    assign bus.cpu_wait = mem_active_c && (cnt < WAIT_N);
    assign bus.cpu_int  = int_c;

    assign io_wr_c.en   = (cyc_c == CYC_IO) && bus.cpu_wr && io_hit_c;
    assign io_wr_c.off  = bus.cpu_addr[1:0];
    assign io_wr_c.data = bus.cpu_do;

    // An access cut by reset stays dead until the CPU drops the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            mem_abort <= 1'b1;
        end else begin
            if (cyc_c == CYC_MEM && !mem_abort)
                cnt <= (cnt < WAIT_N) ? cnt + CNT_W'(1) : '0;
            else
                cnt <= '0;
            if (cyc_c != CYC_MEM)
                mem_abort <= 1'b0;
        end
    end

    always_comb begin
        io_rdata_c = IDLE_DATA;
        if (io_hit_c) begin
            case (bus.cpu_addr[1:0])
                REG_MASK:   io_rdata_c = mask;
                REG_PEND:   io_rdata_c = pend;
                REG_VBASE:  io_rdata_c = vbase;
                REG_STATUS: io_rdata_c = {6'b0, bus.cpu_halt, int_c};
                default:    io_rdata_c = IDLE_DATA;
            endcase
        end
    end

    always_comb begin
        bus.cpu_di = IDLE_DATA;
        case (cyc_c)
            CYC_MEM: if (mem_ready_c && !bus.cpu_wr) bus.cpu_di = mem_rdata;
            CYC_IO:  if (!bus.cpu_wr) bus.cpu_di = io_rdata_c;
            CYC_ACK: bus.cpu_di = vec_c;
            default: bus.cpu_di = IDLE_DATA;
        endcase
    end

    z80_irq_ctrl u_irq (
        .clk     (clk),
        .rst     (rst),
        .irq_req (irq_req),
        .nmi_req (nmi_req),
        .io_wr   (io_wr_c),
        .ack     (cyc_c == CYC_ACK),
        .mask    (mask),
        .pend    (pend),
        .vbase   (vbase),
        .int_c   (int_c),
        .vec_c   (vec_c),
        .nmi     (bus.cpu_nmi)
    );

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed vector bench for z80_bus_responder (MEM_WAIT=2 main instance, MEM_WAIT=1 side instance).
module tb_z80_bus_responder;

    localparam int K_I = 0;
    localparam int K_M = 1;
    localparam int K_O = 2;
    localparam int K_A = 3;
    localparam int K_X = 4;

    typedef struct {
        string      name;
        int         kind;
        logic       wr;
        logic       halt;
        logic [15:0] addr;
        logic [7:0] dout;
        logic [7:0] rdata;
        logic [7:0] irq;
        logic       wt;
        logic       we;
        logic       intr;
        logic [7:0] di;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  mem_rdata;
    logic [7:0]  irq_req;
    logic        nmi_req;
    logic [15:0] mem_addr1, mem_addr2;
    logic [7:0]  mem_wdata1, mem_wdata2;
    logic        mem_we1, mem_we2;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    z80_bus_responder_if bus1();
    z80_bus_responder_if bus2();

    z80_bus_responder #(.MEM_WAIT(2), .IO_BASE(8'hF0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .mem_addr  (mem_addr1),
        .mem_wdata (mem_wdata1),
        .mem_we    (mem_we1),
        .mem_rdata (mem_rdata),
        .irq_req   (irq_req),
        .nmi_req   (nmi_req)
    );

    z80_bus_responder #(.MEM_WAIT(1), .IO_BASE(8'hF0)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .mem_addr  (mem_addr2),
        .mem_wdata (mem_wdata2),
        .mem_we    (mem_we2),
        .mem_rdata (mem_rdata),
        .irq_req   (irq_req),
        .nmi_req   (nmi_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drv(input int kind, input logic wr, input logic halt,
                       input logic [15:0] addr, input logic [7:0] dout);
        logic mreq, iorq, m1;
        mreq = (kind == K_M) || (kind == K_X);
        iorq = (kind == K_O) || (kind == K_A) || (kind == K_X);
        m1   = (kind == K_A);
        bus1.cpu_mreq = mreq; bus2.cpu_mreq = mreq;
        bus1.cpu_iorq = iorq; bus2.cpu_iorq = iorq;
        bus1.cpu_m1   = m1;   bus2.cpu_m1   = m1;
        bus1.cpu_wr   = wr;   bus2.cpu_wr   = wr;
        bus1.cpu_halt = halt; bus2.cpu_halt = halt;
        bus1.cpu_addr = addr; bus2.cpu_addr = addr;
        bus1.cpu_do   = dout; bus2.cpu_do   = dout;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input int kind, input logic wr, input logic halt,
                       input logic [15:0] addr, input logic [7:0] dout, input logic [7:0] rdata,
                       input logic [7:0] irq, input logic wt, input logic we, input logic intr,
                       input logic [7:0] di);
        vec_t v;
        v.name = n; v.kind = kind; v.wr = wr; v.halt = halt; v.addr = addr; v.dout = dout;
        v.rdata = rdata; v.irq = irq; v.wt = wt; v.we = we; v.intr = intr; v.di = di;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        mem_rdata = 8'h00;
        irq_req = 8'h00;
        nmi_req = 1'b0;
        drv(K_I, 1'b0, 1'b0, 16'h0000, 8'h00);

        // name        kind wr halt addr      dout   rdata  irq    wt we int di
        add("idle0",   K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("rd_w0",   K_M, 0, 0, 16'h1234, 8'h00, 8'hA5, 8'h00, 1, 0, 0, 8'hFF);
        add("rd_w1",   K_M, 0, 0, 16'h1234, 8'h00, 8'hA5, 8'h00, 1, 0, 0, 8'hFF);
        add("rd_done", K_M, 0, 0, 16'h1234, 8'h00, 8'hA5, 8'h00, 0, 0, 0, 8'hA5);
        add("idle1",   K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("wr_mask", K_O, 1, 0, 16'h00F0, 8'h0A, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("wr_vb",   K_O, 1, 0, 16'h00F2, 8'h8F, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("rd_vb",   K_O, 0, 0, 16'h00F2, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h80);
        add("rd_mask", K_O, 0, 0, 16'h00F0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h0A);
        add("irq13",   K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h0A, 0, 0, 0, 8'hFF);
        add("int_on",  K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hFF);
        add("rd_pend", K_O, 0, 0, 16'h00F1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h0A);
        add("ack1",    K_A, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h82);
        add("ack1_hd", K_A, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h82);
        add("idle2",   K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'hFF);
        add("ack2",    K_A, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h86);
        add("int_off", K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("ack_non", K_A, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("st_halt", K_O, 0, 1, 16'h00F3, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02);
        add("mask0",   K_O, 1, 0, 16'h00F0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("irq2",    K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h04, 0, 0, 0, 8'hFF);
        add("masked",  K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("st_zero", K_O, 0, 0, 16'h00F3, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add("pend04",  K_O, 0, 0, 16'h00F1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h04);
        add("w1c",     K_O, 1, 0, 16'h00F1, 8'h04, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("pend00",  K_O, 0, 0, 16'h00F1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add("w1c_set", K_O, 1, 0, 16'h00F1, 8'h04, 8'h00, 8'h04, 0, 0, 0, 8'hFF);
        add("set_win", K_O, 0, 0, 16'h00F1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h04);
        add("unmap5",  K_O, 0, 0, 16'h00F5, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("unmap4",  K_O, 0, 0, 16'h00F4, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("mreqiorq",K_X, 0, 0, 16'h00F1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);
        add("b2b_a0",  K_M, 0, 0, 16'h0040, 8'h00, 8'h11, 8'h00, 1, 0, 0, 8'hFF);
        add("b2b_a1",  K_M, 0, 0, 16'h0040, 8'h00, 8'h11, 8'h00, 1, 0, 0, 8'hFF);
        add("b2b_a2",  K_M, 0, 0, 16'h0040, 8'h00, 8'h11, 8'h00, 0, 0, 0, 8'h11);
        add("b2b_b0",  K_M, 0, 0, 16'h0041, 8'h00, 8'h22, 8'h00, 1, 0, 0, 8'hFF);
        add("b2b_b1",  K_M, 0, 0, 16'h0041, 8'h00, 8'h22, 8'h00, 1, 0, 0, 8'hFF);
        add("b2b_b2",  K_M, 0, 0, 16'h0041, 8'h00, 8'h22, 8'h00, 0, 0, 0, 8'h22);
        add("wr_w0",   K_M, 1, 0, 16'h0042, 8'h55, 8'h00, 8'h00, 1, 0, 0, 8'hFF);
        add("wr_w1",   K_M, 1, 0, 16'h0042, 8'h55, 8'h00, 8'h00, 1, 0, 0, 8'hFF);
        add("wr_done", K_M, 1, 0, 16'h0042, 8'h55, 8'h00, 8'h00, 0, 1, 0, 8'hFF);
        add("idle3",   K_I, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'hFF);

        // Reset state
        @(negedge clk);
        chk("rst_wait", bus1.cpu_wait, 1'b0);
        chk("rst_int",  bus1.cpu_int,  1'b0);
        chk("rst_nmi",  bus1.cpu_nmi,  1'b0);
        chk("rst_we",   mem_we1,       1'b0);
        chk("rst_di",   bus1.cpu_di,   8'hFF);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drv(v.kind, v.wr, v.halt, v.addr, v.dout);
            mem_rdata = v.rdata;
            irq_req = v.irq;
            @(negedge clk);
            chk($sformatf("%s_wait", v.name), bus1.cpu_wait, v.wt);
            chk($sformatf("%s_we", v.name), mem_we1, v.we);
            chk($sformatf("%s_int", v.name), bus1.cpu_int, v.intr);
            chk($sformatf("%s_di", v.name), bus1.cpu_di, v.di);
            if (v.kind == K_M)
                chk($sformatf("%s_maddr", v.name), mem_addr1, v.addr);
            tick();
        end

        // Single-wait memory write on the MEM_WAIT=1 instance
        drv(K_M, 1'b1, 1'b0, 16'h8000, 8'h3C);
        @(negedge clk);
        chk("w1_wait0", bus2.cpu_wait, 1'b1);
        chk("w1_we0",   mem_we2, 1'b0);
        chk("w1_addr",  mem_addr2, 16'h8000);
        tick();
        @(negedge clk);
        chk("w1_wait1", bus2.cpu_wait, 1'b0);
        chk("w1_we1",   mem_we2, 1'b1);
        chk("w1_wdata", mem_wdata2, 8'h3C);
        tick();
        drv(K_I, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("w1_we2",   mem_we2, 1'b0);
        tick();

        // NMI: one-clock pulse the clock after the rising edge, even with nmi_req held
        nmi_req = 1'b1;
        @(negedge clk);
        chk("nmi_pre",  bus1.cpu_nmi, 1'b0);
        tick();
        @(negedge clk);
        chk("nmi_hi",   bus1.cpu_nmi, 1'b1);
        tick();
        @(negedge clk);
        chk("nmi_lo",   bus1.cpu_nmi, 1'b0);
        nmi_req = 1'b0;
        tick();

        // Reset in the second wait clock of a write aborts the access for good
        drv(K_M, 1'b1, 1'b0, 16'h2000, 8'h77);
        @(negedge clk);
        chk("ab_wait0", bus1.cpu_wait, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("ab_rwait", bus1.cpu_wait, 1'b0);
        chk("ab_rwe",   mem_we1, 1'b0);
        tick();
        @(negedge clk);
        chk("ab_rwe2",  mem_we1, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ab_we%0d", k), mem_we1, 1'b0);
            chk($sformatf("ab_wt%0d", k), bus1.cpu_wait, 1'b0);
            tick();
        end
        drv(K_I, 1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
        drv(K_O, 1'b0, 1'b0, 16'h00F5, 8'h00);
        @(negedge clk);
        chk("ab_unmap", bus1.cpu_di, 8'hFF);
        tick();
        drv(K_O, 1'b0, 1'b0, 16'h00F2, 8'h00);
        @(negedge clk);
        chk("ab_vbase", bus1.cpu_di, 8'h00);
        tick();
        drv(K_O, 1'b0, 1'b0, 16'h00F1, 8'h00);
        @(negedge clk);
        chk("ab_pend",  bus1.cpu_di, 8'h00);
        tick();
        drv(K_M, 1'b0, 1'b0, 16'h3000, 8'h00);
        mem_rdata = 8'h5A;
        @(negedge clk);
        chk("re_wait0", bus1.cpu_wait, 1'b1);
        tick();
        @(negedge clk);
        chk("re_wait1", bus1.cpu_wait, 1'b1);
        tick();
        @(negedge clk);
        chk("re_di",    bus1.cpu_di, 8'h5A);
        tick();
        drv(K_I, 1'b0, 1'b0, 16'h0000, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 Parameter MEM_WAIT, default 1: wait cycles inserted per memory access; SHALL be legal for values 1..15.
REQ-002 Parameter IO_BASE, default 8'hF0: I/O base for the 4-register block; ADDR[1:0] of IO_BASE SHALL be 0.
REQ-003 CLK  in  1  sole clock, all state on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 ADDR  in  16  CPU address.
REQ-006 DO  in  8  CPU write data.
REQ-007 WR, MREQ, IORQ, M1, HALT  in  1 each  CPU bus strobes, active-high.
REQ-008 DI  out  8  read data / interrupt vector to CPU.
REQ-009 WAIT  out  1  active-high; holds the CPU in the current bus cycle.
REQ-010 INT  out  1  maskable interrupt request, level, active-high.
REQ-011 NMI  out  1  non-maskable request, one-clock pulse.
REQ-012 mem_addr  out  16  / mem_wdata  out  8  / mem_we  out  1: external synchronous RAM.
REQ-013 mem_rdata  in  8  RAM read data, valid one clock after mem_addr.
REQ-014 irq_req  in  8  synchronous interrupt sources, rising-edge sensitive.
REQ-015 nmi_req  in  1  synchronous NMI source, rising-edge sensitive.

Function
REQ-016 Cycle types: MEM = MREQ&!IORQ; IO = IORQ&!M1; ACK = IORQ&M1; otherwise IDLE. MREQ&IORQ&!M1 SHALL be treated as IDLE.
REQ-017 MEM: mem_addr=ADDR and mem_wdata=DO combinationally; wait counter (4 bit) is 0 in IDLE, increments each clock of a MEM cycle while below MEM_WAIT, returns to 0 once the access completes.
REQ-018 WAIT = MEM & (counter < MEM_WAIT), combinational; IO and ACK cycles SHALL never assert WAIT.
REQ-019 MEM read (!WR): DI = mem_rdata in the first clock with WAIT low.
REQ-020 MEM write (WR): mem_we high for exactly the one clock in which WAIT is low; never during wait clocks.
REQ-021 Back-to-back MEM cycles SHALL restart the counter at 0 for each access.
REQ-022 IO registers, ADDR[7:0] relative to IO_BASE: +0 MASK (R/W); +1 PEND (R, write-1-to-clear); +2 VBASE (R/W, bits[7:4] stored, [3:0] read 0); +3 STATUS (R: {6'b0, HALT, INT}).
REQ-023 IO writes take effect on the clock edge of the IO cycle; IO reads to unmapped ports SHALL return 8'hFF.
REQ-024 PEND[i] sets on a rising edge of irq_req[i] (registered previous value); set SHALL win over simultaneous clear (W1C or ACK).
REQ-025 INT = |(PEND & MASK), registered-free combinational from state.
REQ-026 ACK: idx = lowest set bit of PEND&MASK (bit 0 highest priority); DI = {VBASE[7:4], idx[2:0], 1'b0}; PEND[idx] cleared at that clock edge; no bit eligible -> DI = 8'hFF, no state change.
REQ-027 Multi-clock ACK cycles SHALL clear PEND exactly once, on the first clock (edge-detected ACK).
REQ-028 NMI pulses high for one clock, the clock after a rising edge of nmi_req.
REQ-029 DI = 8'hFF in IDLE and during MEM wait clocks.

Reset
REQ-030 RESET asserted: counter=0, MASK=8'h00, PEND=8'h00, VBASE=8'h00, edge registers=0; WAIT, INT, NMI, mem_we =0 immediately.
REQ-031 RESET mid-access aborts it; no mem_we SHALL occur for the aborted access after RESET releases.

Structure
REQ-032 Shared package holds register offsets (MASK/PEND/VBASE/STATUS), cycle-type enum, and 8'hFF idle-data constant.
REQ-033 One sub-module, z80_irq_ctrl: edge detection, PEND/MASK/VBASE, priority encoder, vector, NMI pulse.

Verification
REQ-034 MEM read ADDR=16'h1234, MEM_WAIT=2, mem_rdata=8'hA5 -> WAIT high 2 clocks, DI=8'hA5 on third, no mem_we.
REQ-035 MEM write DO=8'h3C, MEM_WAIT=1 -> WAIT 1 clock, mem_we exactly 1 clock with mem_wdata=8'h3C.
REQ-036 Write MASK=8'h0A, VBASE=8'h80; pulse irq_req[1] and [3] same clock -> INT=1; ACK -> DI=8'h82, second ACK -> DI=8'h86, INT=0.
REQ-037 PEND[2] set, MASK=0 -> INT=0, STATUS=8'h00; write PEND=8'h04 -> PEND reads 8'h00; re-edge same clock as clear -> PEND reads 8'h04.
REQ-038 RESET during second wait clock of MEM write -> WAIT=0, no mem_we; IO read of IO_BASE+5 -> 8'hFF.
